rand_seq_counter: RTL and testbench

RAND_SEQ_COUNTER -- requirements
Module: rand_seq_counter

---
 rtl/rand_seq_pkg.sv | 38 +++
 rtl/rand_seq_step.sv | 53 +++++
 rtl/rand_seq_counter.sv | 75 +++++++
 tb/tb_rand_seq_counter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rand_seq_pkg.sv
// Shared types and constants for the rand_seq_counter slice: step modes and
// a table of maximal-length Galois tap masks (right-shift form) for widths 3..16.
package rand_seq_pkg;

  typedef enum logic [1:0] {
    SEQ_UP   = 2'b00,
    SEQ_DOWN = 2'b01,
    SEQ_LFSR = 2'b10,
    SEQ_HOLD = 2'b11
  } seq_mode_e;

  localparam int SEQ_MIN_WIDTH = 3;
  localparam int SEQ_MAX_WIDTH = 16;

  // Taps for lsb-out, shift-right Galois LFSRs; each gives period 2^w-1.
  function automatic logic [15:0] max_poly(input int width);
    logic [15:0] taps;
    case (width)
      3:       taps = 16'h0006;
      4:       taps = 16'h000C;
      5:       taps = 16'h0014;
      6:       taps = 16'h0030;
      7:       taps = 16'h0060;
      8:       taps = 16'h00B8;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0829;
      13:      taps = 16'h100D;
      14:      taps = 16'h2015;
      15:      taps = 16'h6000;
      16:      taps = 16'hD008;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/rand_seq_step.sv
// Combinational next-value and wrap-condition logic for one counter step;
// the caller decides whether the step is actually taken.
module rand_seq_step
  import rand_seq_pkg::*;
#(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] POLY  = 'h6,
  parameter logic [WIDTH-1:0] SEED  = 1
) (
  input  logic [WIDTH-1:0] cur,
  input  seq_mode_e        mode,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap_hit
);

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] shifted;

  assign shifted = cur >> 1;

  // A zero state would lock the LFSR, so it is steered back to SEED silently.
  always_comb begin
    nxt      = cur;
    wrap_hit = 1'b0;
    case (mode)
      SEQ_UP: begin
        nxt      = cur + ONE;
        wrap_hit = (cur == ALL_ONES);
      end
      SEQ_DOWN: begin
        nxt      = cur - ONE;
        wrap_hit = (cur == ZERO);
      end
      SEQ_LFSR: begin
        if (cur == ZERO) begin
          nxt      = SEED;
          wrap_hit = 1'b0;
        end else begin
          nxt      = cur[0] ? (shifted ^ POLY) : shifted;
          wrap_hit = ((cur[0] ? (shifted ^ POLY) : shifted) == SEED);
        end
      end
      default: begin
        nxt      = cur;
        wrap_hit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/rand_seq_counter.sv
// Up/down/LFSR/hold counter with synchronous load and a one-cycle wrap pulse.
// Define RAND_SEQ_COUNTER_GRAY_EN to add a registered Gray-coded copy of led.
module rand_seq_counter
  import rand_seq_pkg::*;
#(
  parameter int               WIDTH = 3,
  parameter logic [WIDTH-1:0] POLY  = 'h6,
  parameter logic [WIDTH-1:0] SEED  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             wrap
`ifdef RAND_SEQ_COUNTER_GRAY_EN
  ,
  output logic [WIDTH-1:0] gray
`endif
);

  seq_mode_e        mode_e;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;
  logic [WIDTH-1:0] led_d;
  logic             wrap_d;

  assign mode_e = seq_mode_e'(mode);

  rand_seq_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_step (
    .cur      (led),
    .mode     (mode_e),
    .nxt      (step_val),
    .wrap_hit (step_wrap)
  );

  // Load beats stepping; loading zero in LFSR mode would lock it, so use SEED.
  always_comb begin
    led_d  = led;
    wrap_d = 1'b0;
    if (load) begin
      led_d = ((mode_e == SEQ_LFSR) && (load_val == '0)) ? SEED : load_val;
    end else if (en) begin
      led_d  = step_val;
      wrap_d = step_wrap;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led  <= SEED;
      wrap <= 1'b0;
    end else begin
      led  <= led_d;
      wrap <= wrap_d;
    end
  end

`ifdef RAND_SEQ_COUNTER_GRAY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gray <= SEED ^ (SEED >> 1);
    end else begin
      gray <= led_d ^ (led_d >> 1);
    end
  end
`endif

endmodule

// File: tb/tb_rand_seq_counter.sv
// Directed scoreboard bench for rand_seq_counter: a 3-bit instance for the
// mode/load/reset behaviour and an 8-bit instance for full LFSR period.
module tb_rand_seq_counter;
  import rand_seq_pkg::*;

  localparam logic [7:0] POLY8 = 8'(max_poly(8));

  typedef struct {
    logic [2:0] led;
    logic       wrap;
    string      tag;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] led;
  logic       wrap;
  logic       en8;
  logic [1:0] mode8;
  logic [7:0] led8;
  logic       wrap8;
`ifdef RAND_SEQ_COUNTER_GRAY_EN
  logic [2:0] gray;
  logic [7:0] gray8;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb[$];
  logic [15:0] m_led;
  logic [15:0] m_led8;

  rand_seq_counter #(.WIDTH(3), .POLY(3'h6), .SEED(3'd1)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .load_val (load_val),
    .led      (led),
    .wrap     (wrap)
`ifdef RAND_SEQ_COUNTER_GRAY_EN
    ,
    .gray     (gray)
`endif
  );

  rand_seq_counter #(.WIDTH(8), .POLY(POLY8), .SEED(8'd1)) dut8 (
    .clk      (clk),
    .reset    (reset),
    .en       (en8),
    .mode     (mode8),
    .load     (1'b0),
    .load_val (8'd0),
    .led      (led8),
    .wrap     (wrap8)
`ifdef RAND_SEQ_COUNTER_GRAY_EN
    ,
    .gray     (gray8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference stepping written from the mode descriptions, independent of width.
  function automatic void modelStep(input logic [15:0] cur, input int w,
                                    input logic [15:0] poly, input logic [1:0] m,
                                    output logic [15:0] nxt, output logic wr);
    logic [15:0] mask;
    mask = 16'((32'd1 << w) - 1);
    nxt  = cur;
    wr   = 1'b0;
    case (m)
      2'b00: begin nxt = (cur + 16'd1) & mask; wr = (cur == mask); end
      2'b01: begin nxt = (cur - 16'd1) & mask; wr = (cur == 16'd0); end
      2'b10: begin
        if (cur == 16'd0) nxt = 16'd1;
        else begin
          nxt = cur[0] ? ((cur >> 1) ^ poly) : (cur >> 1);
          wr  = (nxt == 16'd1);
        end
      end
      default: ;
    endcase
  endfunction

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checkVal("sb_empty", 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      checkVal({e.tag, "_led"}, 16'(led), 16'(e.led));
      checkVal({e.tag, "_wrap"}, 16'(wrap), 16'(e.wrap));
`ifdef RAND_SEQ_COUNTER_GRAY_EN
      checkVal({e.tag, "_gray"}, 16'(gray), 16'(e.led ^ (e.led >> 1)));
`endif
    end
  endtask

  task automatic applyStimulus(input string tag, input logic e, input logic [1:0] m,
                               input logic l, input logic [2:0] lv);
    exp_t        x;
    logic [15:0] nxt;
    logic        wr;
    @(negedge clk);
    en = e; mode = m; load = l; load_val = lv;
    if (l) begin
      nxt = (m == 2'b10 && lv == 3'd0) ? 16'd1 : 16'(lv);
      wr  = 1'b0;
    end else if (e) begin
      modelStep(m_led, 3, 16'h6, m, nxt, wr);
    end else begin
      nxt = m_led;
      wr  = 1'b0;
    end
    m_led  = nxt;
    x.led  = nxt[2:0];
    x.wrap = wr;
    x.tag  = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    logic [2:0]  lfsr_seq [7];
    logic [15:0] nxt8;
    logic        wr8;
    int          wraps8;
    int          wrap_at;

    lfsr_seq = '{3'd6, 3'd3, 3'd7, 3'd5, 3'd4, 3'd2, 3'd1};
    reset = 1'b0; en = 1'b0; mode = 2'b11; load = 1'b0; load_val = 3'd0;
    en8 = 1'b0; mode8 = 2'b11;

    #15 reset = 1'b1;
    #5;
    checkVal("reset_led", 16'(led), 16'd1);
    checkVal("reset_wrap", 16'(wrap), 16'd0);
    checkVal("reset_led8", 16'(led8), 16'd1);
`ifdef RAND_SEQ_COUNTER_GRAY_EN
    checkVal("reset_gray", 16'(gray), 16'd1);
`endif
    #5 reset = 1'b0;
    m_led = 16'd1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus("lfsr", 1'b1, 2'b10, 1'b0, 3'd0);
      checkVal("lfsr_seq", 16'(led), 16'(lfsr_seq[i]));
    end

    applyStimulus("load6", 1'b0, 2'b00, 1'b1, 3'd6);
    applyStimulus("up7", 1'b1, 2'b00, 1'b0, 3'd0);
    applyStimulus("up0", 1'b1, 2'b00, 1'b0, 3'd0);
    checkVal("up_wrap_const", 16'(wrap), 16'd1);
    applyStimulus("up1", 1'b1, 2'b00, 1'b0, 3'd0);
    applyStimulus("dn0", 1'b1, 2'b01, 1'b0, 3'd0);
    applyStimulus("dn7", 1'b1, 2'b01, 1'b0, 3'd0);
    checkVal("dn_wrap_const", 16'(wrap), 16'd1);

    applyStimulus("up_to0", 1'b1, 2'b00, 1'b0, 3'd0);
    applyStimulus("lock1", 1'b1, 2'b10, 1'b0, 3'd0);
    checkVal("lock_led_const", 16'(led), 16'd1);
    applyStimulus("lfsr6", 1'b1, 2'b10, 1'b0, 3'd0);
    applyStimulus("lfsr3", 1'b1, 2'b10, 1'b0, 3'd0);

    applyStimulus("ld0_lfsr", 1'b1, 2'b10, 1'b1, 3'd0);
    checkVal("ld0_lfsr_const", 16'(led), 16'd1);
    applyStimulus("ld0_up", 1'b1, 2'b00, 1'b1, 3'd0);
    checkVal("ld0_up_const", 16'(led), 16'd0);
    applyStimulus("ld4_lfsr", 1'b1, 2'b10, 1'b1, 3'd4);
    applyStimulus("ld_wins", 1'b1, 2'b00, 1'b1, 3'd5);
    checkVal("ld_wins_const", 16'(led), 16'd5);

    // Reset mid-cycle with load and en active; it must act before any edge.
    @(negedge clk);
    #2;
    reset = 1'b1; load = 1'b1; en = 1'b1; mode = 2'b00; load_val = 3'd3;
    #1;
    checkVal("async_led", 16'(led), 16'd1);
    checkVal("async_wrap", 16'(wrap), 16'd0);
    @(posedge clk);
    #1;
    checkVal("rst_over_load", 16'(led), 16'd1);
    @(negedge clk);
    reset = 1'b0; load = 1'b0; en = 1'b0;
    m_led = 16'd1;

    applyStimulus("pre_hold", 1'b1, 2'b10, 1'b0, 3'd0);
    for (int i = 0; i < 10; i++) applyStimulus("hold_en0", 1'b0, 2'b00, 1'b0, 3'd0);
    for (int i = 0; i < 10; i++) applyStimulus("hold_m11", 1'b1, 2'b11, 1'b0, 3'd0);

    @(negedge clk);
    en = 1'b0;
    en8 = 1'b1; mode8 = 2'b10;
    m_led8 = 16'd1;
    wraps8 = 0;
    wrap_at = 0;
    for (int i = 1; i <= 255; i++) begin
      @(posedge clk);
      #1;
      modelStep(m_led8, 8, 16'(POLY8), 2'b10, nxt8, wr8);
      m_led8 = nxt8;
      checkVal("w8_led", 16'(led8), m_led8);
      checkVal("w8_wrap", 16'(wrap8), 16'(wr8));
`ifdef RAND_SEQ_COUNTER_GRAY_EN
      checkVal("w8_gray", 16'(gray8), 16'(led8 ^ (led8 >> 1)));
`endif
      if (wrap8 === 1'b1) begin
        wraps8++;
        wrap_at = i;
      end
    end
    @(negedge clk);
    en8 = 1'b0;
    checkVal("w8_wrap_count", 16'(wraps8), 16'd1);
    checkVal("w8_period", 16'(wrap_at), 16'd255);
    checkVal("w8_final", 16'(led8), 16'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
